// File: rtl/serial_adder_pkg.sv
// Types shared by the serial adder: FSM state encoding.
// Encoding 2'd3 is never produced and decodes back to S_IDLE.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_adder_fa.sv
// One-bit full adder built from two half adders and an OR on the carries.
// Purely combinational; the serial adder instantiates exactly one of these.
module ha (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;
endmodule

module fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  logic s0, c0, c1;

  ha u_ha0 (.a_i(a_i), .b_i(b_i), .s_o(s0),  .c_o(c0));
  ha u_ha1 (.a_i(s0),  .b_i(c_i), .s_o(s_o), .c_o(c1));

  assign c_o = c0 | c1;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, LSB first; done pulses WIDTH clocks after the accepted start.
// start is only sampled in IDLE or DONE, so requests made while busy are silently dropped.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, acc_q, sum_q;
  logic [WIDTH-1:0] acc_d;
  logic [CNT_W-1:0] bit_cnt_q;
  logic             carry_q, cout_q, busy_q, done_q;
  logic             fa_s, fa_co;

  fa u_fa (
    .a_i (a_sh_q[0]),
    .b_i (b_sh_q[0]),
    .c_i (carry_q),
    .s_o (fa_s),
    .c_o (fa_co)
  );

  // Each new sum bit enters at the MSB, so after WIDTH shifts bit 0 sits at the LSB.
  assign acc_d = {fa_s, acc_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      acc_q     <= '0;
      carry_q   <= 1'b0;
      bit_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            a_sh_q    <= a;
            b_sh_q    <= b;
            carry_q   <= cin;
            acc_q     <= '0;
            bit_cnt_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= S_ADD;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_ADD: begin
          a_sh_q    <= a_sh_q >> 1;
          b_sh_q    <= b_sh_q >> 1;
          acc_q     <= acc_d;
          carry_q   <= fa_co;
          bit_cnt_q <= bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == LAST_BIT) begin
            sum_q   <= acc_d;
            cout_q  <= fa_co;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
endmodule
